fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Sequences the instruction-fetch path. Owns the program counter and drives the byte-addressed instruction ROM. Buffers fetched {pc, instr} pairs in a small in-order fetch queue, handing them to decode via a valid/ready handshake. Handles redirects (branch/flush) and halts cleanly at the end of the loaded trace.

Parameters:
ADDR_WIDTH, 12, ROM byte-address width.
DEPTH, 4, fetch-queue entries (power of two, >=2).
RESET_PC, 32'h00000000, PC value after reset.
TRACE_BYTES, 48, byte length of loaded trace; fetch stops when pc >= TRACE_BYTES.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high
rom_addr  out  ADDR_WIDTH  ROM byte address = pc[ADDR_WIDTH-1:0]
rom_data  in  32  instruction word from ROM (combinational, same cycle)
redirect_valid  in  1  flush queue and load redirect_pc
redirect_pc  in  32  new fetch PC
out_valid  out  1  head entry available to decode
out_ready  in  1  decode accepts head entry
out_pc  out  32  PC of head entry
out_instr  out  32  instruction of head entry
fq_count  out  clog2(DEPTH+1)  current queue occupancy
halted  out  1  trace exhausted and queue drained

Behaviour:
- Reset (sync, active-high): pc=RESET_PC, state=RUN, queue empty, fq_count=0, out_valid=0, halted=0. Reset overrides all other inputs.
- States: RUN, DRAIN, HALT. halted=1 only in HALT.
- RUN: when pc < TRACE_BYTES and fq_count < DEPTH (start-of-cycle value), push {pc, rom_data}; pc <= pc+4. No push-through-full: a pop in the same cycle does not free a slot for that cycle's push. If pc >= TRACE_BYTES: no push, go to DRAIN.
- DRAIN: no fetch, pc holds. Goes to HALT in the cycle after fq_count reaches 0.
- HALT: pc holds, no fetch, out_valid=0. Only redirect or reset leaves HALT.
- Dequeue: out_valid = (fq_count != 0) and not redirect_valid. out_pc/out_instr come from the registered head entry. Pop occurs when out_valid and out_ready. Push and pop in the same cycle leave fq_count unchanged.
- Latency: an instruction fetched in cycle N is visible on out_* in cycle N+1 when the queue was empty. Sustained throughput is 1 instr/cycle with out_ready=1.
- Redirect (highest priority after reset): in a redirect_valid cycle there is no push and no pop. Next cycle: queue empty, pc = {redirect_pc[31:2], 2'b00}, state=RUN, halted=0.
- rom_addr is driven from the pc register only. It holds steady while the queue is full.
- pc arithmetic is 32-bit modulo 2^32. Only low ADDR_WIDTH bits reach the ROM.
- Queue pointers wrap modulo DEPTH. fq_count ranges 0..DEPTH.

Optional Feature:
FETCH_STATS_EN. When defined, two extra output ports are added:
- stat_fetched[31:0]: counts pushes.
- stat_stall[31:0]: counts RUN cycles with pc < TRACE_BYTES and queue full.
Both counters clear on reset, are unaffected by redirect, and saturate at 32'hFFFFFFFF. When undefined, the ports and counters are absent and the core behaviour is identical.

Test Plan:
1. Reset, out_ready=1, TRACE_BYTES=48, ROM preloaded -> out_pc 0x00,0x04,...,0x2C on consecutive cycles with matching instrs; first out_valid 1 cycle after reset release; halted=1 two cycles after pc 0x2C dequeues; out_valid stays 0 afterward.
2. out_ready=0 from reset -> fq_count climbs 1..4 and sticks at 4; rom_addr holds 0x010. Raise out_ready -> out_pc 0x00,0x04,0x08,0x0C,0x10 in order, no gaps.
3. fq_count=3, redirect_valid=1, redirect_pc=0x20 -> out_valid=0 that cycle; next cycle fq_count=0, rom_addr=0x020; following cycle out_pc=0x20; old entries never appear.
4. Redirect with redirect_pc=0x22 -> next fetched out_pc=0x20.
5. Reset asserted mid-run with fq_count=2 -> next cycle fq_count=0, out_valid=0, rom_addr=0x000, halted=0.
6. In HALT, redirect to 0x08 -> halted=0 next cycle; out_pc 0x08,0x0C,... through 0x2C, then HALT again.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//
// Instruction-fetch sequencer. Owns the program counter, addresses a
// byte-addressed instruction ROM (combinational read), and buffers fetched
// {pc, instr} pairs in a small in-order queue that decode drains through a
// valid/ready handshake. A redirect flushes the queue and restarts fetch at a
// new word-aligned PC. Fetch stops once pc reaches TRACE_BYTES; the block then
// drains the queue and parks in a halted state until redirected or reset.
//
// Parameters
//   ADDR_WIDTH   ROM byte-address width
//   DEPTH        fetch-queue entries (power of two, >= 2)
//   RESET_PC     PC value after reset
//   TRACE_BYTES  byte length of the loaded trace
//
// Ports
//   clk             clock, rising edge
//   reset           synchronous, active-high
//   rom_addr        ROM byte address (low ADDR_WIDTH bits of pc)
//   rom_data        instruction word returned by the ROM in the same cycle
//   redirect_valid  flush the queue and load redirect_pc
//   redirect_pc     new fetch PC (low two bits ignored)
//   out_valid       head entry available to decode
//   out_ready       decode accepts the head entry
//   out_pc          PC of head entry
//   out_instr       instruction of head entry
//   fq_count        queue occupancy, 0..DEPTH
//   halted          trace exhausted and queue drained
//
// Optional build macro FETCH_STATS_EN adds:
//   stat_fetched    saturating count of queue pushes
//   stat_stall      saturating count of RUN cycles blocked by a full queue
// -----------------------------------------------------------------------------
module fetch_ctrl #(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          DEPTH       = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRACE_BYTES = 32'd48
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic [ADDR_WIDTH-1:0]      rom_addr,
  input  logic [31:0]                rom_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_pc,
  output logic [31:0]                out_instr,
  output logic [$clog2(DEPTH+1)-1:0] fq_count,
  output logic                       halted
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]                stat_fetched,
  output logic [31:0]                stat_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  // Architectural state
  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fq_count_q, fq_count_d;

  // Queue storage. Read is asynchronous so the head entry is visible the cycle
  // after it is written; entries are only ever read from registered storage.
  logic [31:0] ent_pc_mem    [DEPTH];
  logic [31:0] ent_instr_mem [DEPTH];

  // Per-cycle decisions
  logic in_trace;
  logic q_full;
  logic q_empty;
  logic out_valid_c;
  logic push;
  logic pop;

  always_comb begin
    in_trace = (pc_q < TRACE_BYTES);
    q_full   = (fq_count_q == DEPTH_CNT);
    q_empty  = (fq_count_q == '0);

    // Redirect hides the head for the flush cycle; HALT always has an empty
    // queue, the extra term just makes out_valid=0 there unconditional.
    out_valid_c = !q_empty && !redirect_valid && (state_q != S_HALT);
    pop         = out_valid_c && out_ready;

    // Fullness is judged on the start-of-cycle count: a same-cycle pop does
    // not make room for this cycle's push.
    push = (state_q == S_RUN) && !redirect_valid && in_trace && !q_full;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    fq_count_d = fq_count_q;

    if (redirect_valid) begin
      state_d    = S_RUN;
      pc_d       = redirect_pc & ~32'd3;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fq_count_d = '0;
    end else begin
      case (state_q)
        S_RUN:   if (!in_trace) state_d = S_DRAIN;
        // Leave DRAIN the cycle after occupancy has been seen at zero.
        S_DRAIN: if (q_empty)   state_d = S_HALT;
        S_HALT:  state_d = S_HALT;
        default: state_d = S_RUN;
      endcase

      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
        2'b10:   fq_count_d = fq_count_q + CNT_ONE;
        2'b01:   fq_count_d = fq_count_q - CNT_ONE;
        default: fq_count_d = fq_count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RUN;
      pc_q       <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fq_count_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fq_count_q <= fq_count_d;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_pc_mem[wr_ptr_q]    <= pc_q;
      ent_instr_mem[wr_ptr_q] <= rom_data;
    end
  end

  assign rom_addr  = pc_q[ADDR_WIDTH-1:0];
  assign out_valid = out_valid_c;
  assign out_pc    = ent_pc_mem[rd_ptr_q];
  assign out_instr = ent_instr_mem[rd_ptr_q];
  assign fq_count  = fq_count_q;
  assign halted    = (state_q == S_HALT);

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [31:0] stat_stall_q, stat_stall_d;
  logic        stall_hit;

  always_comb begin
    stall_hit      = (state_q == S_RUN) && in_trace && q_full;
    stat_fetched_d = stat_fetched_q;
    stat_stall_d   = stat_stall_q;
    if (push && (stat_fetched_q != 32'hFFFF_FFFF)) begin
      stat_fetched_d = stat_fetched_q + 32'd1;
    end
    if (stall_hit && (stat_stall_q != 32'hFFFF_FFFF)) begin
      stat_stall_d = stat_stall_q + 32'd1;
    end
  end

  // Counters survive redirects; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetched_q <= '0;
      stat_stall_q   <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_stall_q   <= stat_stall_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_stall   = stat_stall_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_ctrl
//
// Directed scenarios followed by a randomized phase. A transaction-level model
// (queue of expected {pc, instr} pairs, next fetch PC, end-of-trace flags)
// predicts every visible output each cycle.
// -----------------------------------------------------------------------------
module tb_fetch_ctrl;

  localparam int          AW    = 12;
  localparam int          DEPTH = 4;
  localparam logic [31:0] TRACE = 32'd48;

  logic        clk = 1'b0;
  logic        reset;
  logic [AW-1:0] rom_addr;
  logic [31:0] rom_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  fq_count;
  logic        halted;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_stall;
`endif

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RESET_PC   (32'h0),
    .TRACE_BYTES(TRACE)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rom_addr      (rom_addr),
    .rom_data      (rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr),
    .fq_count      (fq_count),
    .halted        (halted)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_stall    (stat_stall)
`endif
  );

  // Word-addressed ROM image, filled with random words.
  logic [31:0] rom_mem [0:1023];
  assign rom_data = rom_mem[rom_addr[11:2]];

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  // Reference model
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_fetch_over;  // trace end reached, no more fetches
  bit          m_halted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_pc         = 32'h0;
    m_fetch_over = 1'b0;
    m_halted     = 1'b0;
  endtask

  // One clock cycle: drive inputs, check predicted outputs, advance the model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit rst);
    bit   exp_valid;
    bit   do_pop;
    bit   do_push;
    int   sz;
    ent_t e;
    reset          = rst;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    sz        = m_q.size();
    exp_valid = (sz != 0) && !rv && !m_halted;
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
    chk("fq_count", {29'd0, fq_count}, 32'(sz));
    chk("rom_addr", {20'd0, rom_addr}, {20'd0, m_pc[AW-1:0]});
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    if (exp_valid) begin
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_instr", out_instr, m_q[0].instr);
      if (rdy) $display("deq pc=0x%08h instr=0x%08h t=%0t", out_pc, out_instr, $time);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (rv) begin
      m_q.delete();
      m_pc         = rpc & ~32'd3;
      m_fetch_over = 1'b0;
      m_halted     = 1'b0;
    end else begin
      do_pop  = exp_valid && rdy;
      do_push = !m_fetch_over && (m_pc < TRACE) && (sz < DEPTH);
      if (!m_fetch_over && (m_pc >= TRACE)) m_fetch_over = 1'b1;
      else if (m_fetch_over && !m_halted && (sz == 0)) m_halted = 1'b1;
      if (do_pop) void'(m_q.pop_front());
      if (do_push) begin
        e.pc    = m_pc;
        e.instr = rom_mem[m_pc[11:2]];
        m_q.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    bit          r_rdy;
    bit          r_rv;
    bit          r_rst;
    logic [31:0] r_pc;

    for (int i = 0; i < 1024; i++) rom_mem[i] = $urandom;
    reset          = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    @(posedge clk);
    model_reset();
    @(negedge clk);

    // 1: stream the whole trace, then halt
    step(1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t1_halted", {31'd0, halted}, 32'd1);
    chk("t1_valid", {31'd0, out_valid}, 32'd0);

    // 2: back-pressure fills the queue, then release
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t2_full", {29'd0, fq_count}, 32'd4);
    chk("t2_addr", {20'd0, rom_addr}, 32'h010);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // 3: redirect with three entries queued
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    chk("t3_count", {29'd0, fq_count}, 32'd3);
    step(1'b1, 1'b1, 32'h20, 1'b0);
    chk("t3_addr", {20'd0, rom_addr}, 32'h020);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // 4: misaligned redirect target
    step(1'b1, 1'b1, 32'h22, 1'b0);
    chk("t4_addr", {20'd0, rom_addr}, 32'h020);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // 5: reset mid-run
    step(1'b0, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1);
    chk("t5_count", {29'd0, fq_count}, 32'd0);
    chk("t5_addr", {20'd0, rom_addr}, 32'h000);

    // 6: redirect out of HALT
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t6_halt_a", {31'd0, halted}, 32'd1);
    step(1'b1, 1'b1, 32'h08, 1'b0);
    chk("t6_resume", {31'd0, halted}, 32'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("t6_halt_b", {31'd0, halted}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 500; i++) begin
      r_rdy = ($urandom_range(0, 9) < 7);
      r_rv  = ($urandom_range(0, 24) == 0);
      r_rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 9) == 0) r_pc = 32'hFFFF_FFFE;
      else r_pc = 32'($urandom_range(0, 63));
      step(r_rdy, r_rv, r_pc, r_rst);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
